// File: rtl/alu_issue_stage_pkg.sv
// rtl/alu_issue_stage_pkg.sv - shared definitions for the ALU issue stage
package definitions;

    localparam int DW = 8;
    localparam int AW = 3;

    typedef enum logic [2:0] {
        kNOP = 3'd0,
        kADD = 3'd1,
        kSUB = 3'd2,
        kAND = 3'd3,
        kOR  = 3'd4,
        kXOR = 3'd5,
        kLSH = 3'd6,
        kRSH = 3'd7
    } op_mne;

    typedef struct packed {
        op_mne           op;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
        logic [AW-1:0]   dst;
        logic            wen;
    } issue_t;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [AW-1:0]   dst;
        logic            wen;
    } result_t;

    // True when a pipeline entry will write the register a consumer is about to read.
    function automatic logic dst_hit(input logic valid, input logic wen,
                                     input logic [AW-1:0] dst, input logic [AW-1:0] src);
        return valid && wen && (dst == src);
    endfunction

endpackage

// File: rtl/alu_fwd_sel.sv
// rtl/alu_fwd_sel.sv - per-operand forwarding select, built only with ALU_FWD_EN
`ifdef ALU_FWD_EN
import definitions::*;

module alu_fwd_sel #(
    parameter int DW = definitions::DW,
    parameter int AW = definitions::AW
) (
    input  logic [AW-1:0] src_i,
    input  logic [DW-1:0] rf_data_i,
    input  logic          i_valid_i,
    input  logic          i_wen_i,
    input  logic [AW-1:0] i_dst_i,
    input  logic [DW-1:0] i_data_i,
    input  logic          r_valid_i,
    input  logic          r_wen_i,
    input  logic [AW-1:0] r_dst_i,
    input  logic [DW-1:0] r_data_i,
    output logic [DW-1:0] data_o
);

    // Newest producer wins: the op in the issue register, then the held result.
    always_comb begin
        data_o = rf_data_i;
        if (dst_hit(i_valid_i, i_wen_i, i_dst_i, src_i)) begin
            data_o = i_data_i;
        end else if (dst_hit(r_valid_i, r_wen_i, r_dst_i, src_i)) begin
            data_o = r_data_i;
        end
    end

endmodule
`endif

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - issue/result registers around an external ALU; ALU_FWD_EN enables forwarding
import definitions::*;

module alu_issue_stage #(
    parameter int DW = definitions::DW,
    parameter int AW = definitions::AW
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [DW-1:0] in_a,
    input  logic [DW-1:0] in_b,
    input  logic [AW-1:0] in_src_a,
    input  logic [AW-1:0] in_src_b,
    input  logic [AW-1:0] in_dst,
    input  logic          in_wen,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_op,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_zero,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [DW-1:0] wb_data,
    output logic [AW-1:0] wb_dst,
    output logic          wb_wen,
    output logic          zero_flag
);

    logic          i_valid_q, i_valid_d;
    issue_t        i_q, i_d;
    logic          r_valid_q, r_valid_d;
    result_t       r_q, r_d;
    logic          zero_q, zero_d;

    logic          r_take;
    logic          i_take;
    logic          xfer;
    logic          accept;
    logic          stall;
    logic [DW-1:0] a_sel;
    logic [DW-1:0] b_sel;

    // R can load when empty or when writeback takes its current content.
    assign r_take = !r_valid_q || wb_ready;
    assign i_take = !i_valid_q || r_take;
    assign xfer   = i_valid_q && r_take;

`ifdef ALU_FWD_EN
    assign stall = 1'b0;

    alu_fwd_sel #(.DW(DW), .AW(AW)) u_fwd_a (
        .src_i     (in_src_a),
        .rf_data_i (in_a),
        .i_valid_i (i_valid_q),
        .i_wen_i   (i_q.wen),
        .i_dst_i   (i_q.dst),
        .i_data_i  (alu_out),
        .r_valid_i (r_valid_q),
        .r_wen_i   (r_q.wen),
        .r_dst_i   (r_q.dst),
        .r_data_i  (r_q.data),
        .data_o    (a_sel)
    );

    alu_fwd_sel #(.DW(DW), .AW(AW)) u_fwd_b (
        .src_i     (in_src_b),
        .rf_data_i (in_b),
        .i_valid_i (i_valid_q),
        .i_wen_i   (i_q.wen),
        .i_dst_i   (i_q.dst),
        .i_data_i  (alu_out),
        .r_valid_i (r_valid_q),
        .r_wen_i   (r_q.wen),
        .r_dst_i   (r_q.dst),
        .r_data_i  (r_q.data),
        .data_o    (b_sel)
    );
`else
    // Without forwarding, hold the consumer until every matching producer has left R.
    assign stall = in_valid &&
                   (dst_hit(i_valid_q, i_q.wen, i_q.dst, in_src_a) ||
                    dst_hit(i_valid_q, i_q.wen, i_q.dst, in_src_b) ||
                    dst_hit(r_valid_q, r_q.wen, r_q.dst, in_src_a) ||
                    dst_hit(r_valid_q, r_q.wen, r_q.dst, in_src_b));
    assign a_sel = in_a;
    assign b_sel = in_b;
`endif

    assign in_ready = i_take && !stall;
    assign accept   = in_valid && in_ready;

    // Next state of the issue register, the result register and the zero flag.
    always_comb begin
        i_valid_d = i_valid_q;
        i_d       = i_q;
        r_valid_d = r_valid_q;
        r_d       = r_q;
        zero_d    = zero_q;

        if (accept) begin
            i_valid_d = 1'b1;
            i_d.op    = op_mne'(in_op);
            i_d.a     = a_sel;
            i_d.b     = b_sel;
            i_d.dst   = in_dst;
            i_d.wen   = in_wen;
        end else if (xfer) begin
            i_valid_d = 1'b0;
        end

        // A transfer refilling R takes precedence over the drain emptying it.
        if (xfer) begin
            r_valid_d = 1'b1;
            r_d.data  = alu_out;
            r_d.dst   = i_q.dst;
            r_d.wen   = i_q.wen;
            zero_d    = alu_zero;
        end else if (r_valid_q && wb_ready) begin
            r_valid_d = 1'b0;
        end
    end

    // Pipeline state; reset drops every in-flight operation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            i_valid_q <= 1'b0;
            i_q       <= '0;
            r_valid_q <= 1'b0;
            r_q       <= '0;
            zero_q    <= 1'b0;
        end else begin
            i_valid_q <= i_valid_d;
            i_q       <= i_d;
            r_valid_q <= r_valid_d;
            r_q       <= r_d;
            zero_q    <= zero_d;
        end
    end

    assign alu_a     = i_valid_q ? i_q.a : '0;
    assign alu_b     = i_valid_q ? i_q.b : '0;
    assign alu_op    = i_valid_q ? i_q.op : kNOP;

    assign wb_valid  = r_valid_q;
    assign wb_data   = r_q.data;
    assign wb_dst    = r_q.dst;
    assign wb_wen    = r_q.wen;
    assign zero_flag = zero_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
import definitions::*;

module tb_alu_issue_stage;

`ifdef ALU_FWD_EN
    localparam int EXP_DEP_STALLS = 0;
`else
    localparam int EXP_DEP_STALLS = 2;
`endif

    logic       Clk;
    logic       Reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic [7:0] in_a, in_b;
    logic [2:0] in_src_a, in_src_b, in_dst;
    logic       in_wen;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic       wb_valid;
    logic       wb_ready;
    logic [7:0] wb_data;
    logic [2:0] wb_dst;
    logic       wb_wen;
    logic       zero_flag;

    typedef struct {
        logic [7:0] data;
        logic [2:0] dst;
        logic       wen;
        logic       zero;
    } exp_t;

    exp_t       scb[$];
    logic [7:0] rf [8];
    int         total = 0;
    int         bad   = 0;
    int         stalls;

    alu_issue_stage #(.DW(8), .AW(3)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_src_a  (in_src_a),
        .in_src_b  (in_src_b),
        .in_dst    (in_dst),
        .in_wen    (in_wen),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_out   (alu_out),
        .alu_zero  (alu_zero),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_data   (wb_data),
        .wb_dst    (wb_dst),
        .wb_wen    (wb_wen),
        .zero_flag (zero_flag)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference combinational ALU sitting outside the stage.
    always_comb begin
        case (op_mne'(alu_op))
            kADD:    alu_out = alu_a + alu_b;
            kSUB:    alu_out = alu_a - alu_b;
            kAND:    alu_out = alu_a & alu_b;
            kOR:     alu_out = alu_a | alu_b;
            kXOR:    alu_out = alu_a ^ alu_b;
            kLSH:    alu_out = alu_a << 1;
            kRSH:    alu_out = alu_a >> 1;
            default: alu_out = 8'h00;
        endcase
        alu_zero = (alu_out == 8'h00);
    end

    // Register file written by writeback, used to source operands.
    always @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (wb_valid && wb_ready && wb_wen) begin
            rf[wb_dst] <= wb_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every result taken by writeback must match the oldest expectation.
    always @(negedge Clk) begin
        if (!Reset && wb_valid && wb_ready) begin
            if (scb.size() == 0) begin
                check("wb_unexpected", 32'(wb_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = scb.pop_front();
                check("wb_data", 32'(wb_data), 32'(e.data));
                check("wb_dst", 32'(wb_dst), 32'(e.dst));
                check("wb_wen", 32'(wb_wen), 32'(e.wen));
                check("zero_flag", 32'(zero_flag), 32'(e.zero));
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Offer one op until accepted; leaves in_valid high, caller decides what follows.
    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] dst,
                        input logic wen, input logic [7:0] exp_d, input bit use_rf,
                        output int n_stall);
        bit   done;
        exp_t e;
        done     = 1'b0;
        n_stall  = 0;
        in_op    = op;
        in_b     = b;
        in_src_a = sa;
        in_src_b = sb;
        in_dst   = dst;
        in_wen   = wen;
        in_valid = 1'b1;
        for (int c = 0; c < 30 && !done; c++) begin
            in_a = use_rf ? rf[sa] : a;
            @(negedge Clk);
            if (in_ready) begin
                e.data = exp_d;
                e.dst  = dst;
                e.wen  = wen;
                e.zero = (exp_d == 8'h00);
                scb.push_back(e);
                done = 1'b1;
            end else begin
                n_stall++;
            end
            step();
        end
        if (!done) begin
            check("send_timeout", 0, 1);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (scb.size() != 0 && n < 30) begin
            step();
            n++;
        end
        check("drain_empty", 32'(scb.size()), 0);
    endtask

    initial begin
        logic [2:0] bp_op  [3];
        logic [7:0] bp_a   [3];
        logic [7:0] bp_b   [3];
        logic [2:0] bp_dst [3];
        logic [7:0] bp_exp [3];
        int         k;
        int         acc;
        bit         took;
        exp_t       e;

        bp_op[0] = kADD; bp_a[0] = 8'h01; bp_b[0] = 8'h02; bp_dst[0] = 3'd1; bp_exp[0] = 8'h03;
        bp_op[1] = kADD; bp_a[1] = 8'h05; bp_b[1] = 8'h05; bp_dst[1] = 3'd4; bp_exp[1] = 8'h0A;
        bp_op[2] = kOR;  bp_a[2] = 8'h0F; bp_b[2] = 8'h30; bp_dst[2] = 3'd5; bp_exp[2] = 8'h3F;

        Reset    = 1'b1;
        in_valid = 1'b0;
        in_op    = 3'd0;
        in_a     = 8'h00;
        in_b     = 8'h00;
        in_src_a = 3'd0;
        in_src_b = 3'd0;
        in_dst   = 3'd0;
        in_wen   = 1'b0;
        wb_ready = 1'b1;
        step();
        step();
        Reset = 1'b0;

        // Reset state
        @(negedge Clk);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_zero_flag", 32'(zero_flag), 0);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_alu_a", 32'(alu_a), 0);
        step();

        // ADD 3+4 and its two-edge latency
        send(kADD, 8'h03, 8'h04, 3'd6, 3'd7, 3'd1, 1'b1, 8'h07, 1'b0, stalls);
        in_valid = 1'b0;
        @(negedge Clk);
        check("lat_wb_valid_n1", 32'(wb_valid), 0);
        check("lat_alu_op", 32'(alu_op), 32'(kADD));
        check("lat_alu_a", 32'(alu_a), 32'h03);
        check("lat_alu_b", 32'(alu_b), 32'h04);
        step();
        @(negedge Clk);
        check("lat_wb_valid_n2", 32'(wb_valid), 1);
        step();
        drain();

        // XOR to zero then AND, back to back
        send(kXOR, 8'h55, 8'h55, 3'd6, 3'd7, 3'd4, 1'b1, 8'h00, 1'b0, stalls);
        send(kAND, 8'hF0, 8'h3C, 3'd6, 3'd7, 3'd5, 1'b1, 8'h30, 1'b0, stalls);
        in_valid = 1'b0;
        drain();

        // Dependent pair: operand A of the second op comes from the first
        send(kADD, 8'h10, 8'h01, 3'd6, 3'd7, 3'd2, 1'b1, 8'h11, 1'b0, stalls);
        check("dep_first_stalls", 32'(stalls), 0);
        send(kADD, 8'h00, 8'h01, 3'd2, 3'd7, 3'd3, 1'b1, 8'h12, 1'b1, stalls);
        check("dep_stalls", 32'(stalls), 32'(EXP_DEP_STALLS));
        in_valid = 1'b0;
        drain();

        // Back-pressure: writeback stalled for 4 cycles while 3 ops are offered
        wb_ready = 1'b0;
        k   = 0;
        acc = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_op    = bp_op[k];
            in_a     = bp_a[k];
            in_b     = bp_b[k];
            in_src_a = 3'd6;
            in_src_b = 3'd7;
            in_dst   = bp_dst[k];
            in_wen   = 1'b1;
            in_valid = 1'b1;
            took     = 1'b0;
            @(negedge Clk);
            if (in_ready) begin
                e.data = bp_exp[k];
                e.dst  = bp_dst[k];
                e.wen  = 1'b1;
                e.zero = 1'b0;
                scb.push_back(e);
                took = 1'b1;
                acc++;
            end
            if (cyc >= 2) begin
                check("bp_in_ready", 32'(in_ready), 0);
                check("bp_wb_valid", 32'(wb_valid), 1);
                check("bp_wb_data", 32'(wb_data), 32'h03);
                check("bp_wb_dst", 32'(wb_dst), 1);
                check("bp_zero_flag", 32'(zero_flag), 0);
            end
            step();
            if (took) k++;
        end
        check("bp_accepted", 32'(acc), 2);
        wb_ready = 1'b1;
        send(bp_op[2], bp_a[2], bp_b[2], 3'd6, 3'd7, bp_dst[2], 1'b1, bp_exp[2], 1'b0, stalls);
        in_valid = 1'b0;
        drain();

        // Shifts with wen=0: a matching source must not be forwarded or stalled
        send(kLSH, 8'h81, 8'h00, 3'd6, 3'd7, 3'd3, 1'b0, 8'h02, 1'b0, stalls);
        send(kRSH, 8'h81, 8'h00, 3'd3, 3'd3, 3'd3, 1'b0, 8'h40, 1'b0, stalls);
        check("nowen_stalls", 32'(stalls), 0);
        in_valid = 1'b0;
        drain();

        // Reset while both registers hold operations
        wb_ready = 1'b0;
        send(kXOR, 8'h33, 8'h33, 3'd6, 3'd7, 3'd1, 1'b1, 8'h00, 1'b0, stalls);
        send(kADD, 8'h01, 8'h01, 3'd6, 3'd7, 3'd4, 1'b1, 8'h02, 1'b0, stalls);
        in_valid = 1'b0;
        @(negedge Clk);
        check("pre_rst_wb_valid", 32'(wb_valid), 1);
        check("pre_rst_zero_flag", 32'(zero_flag), 1);
        check("pre_rst_alu_op", 32'(alu_op), 32'(kADD));
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        scb.delete();
        @(negedge Clk);
        check("post_rst_wb_valid", 32'(wb_valid), 0);
        check("post_rst_zero_flag", 32'(zero_flag), 0);
        check("post_rst_in_ready", 32'(in_ready), 1);
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        @(negedge Clk);
        check("post_rst_quiet", 32'(wb_valid), 0);
        check("scb_final_empty", 32'(scb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
